// File: rtl/count_sequencer.sv
// count_sequencer: steps a free-running `count` instance through a table of
// interval segments by reloading its match_value on every accepted match.
// Optional repeat counter is compiled in with `define COUNT_SEQ_REPEAT_EN.
module count_sequencer #(
  parameter int unsigned BIN  = 32,
  parameter int unsigned SEGS = 4,
  parameter int unsigned AW   = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [BIN-1:0] cfg_data,
  input  logic [AW:0]    seg_count,
  input  logic           loop,
  input  logic           start,
  input  logic           stop,
`ifdef COUNT_SEQ_REPEAT_EN
  input  logic [7:0]     rep_count,
  output logic [7:0]     rep_left,
`endif
  input  logic [BIN-1:0] cnt_value,
  input  logic           cnt_match,
  output logic           cnt_enable,
  output logic [BIN-1:0] cnt_match_value,
  output logic [AW-1:0]  seg_idx,
  output logic           seg_pulse,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t         state;
  logic [BIN-1:0] tbl [SEGS];
  logic [AW-1:0]  seg_last;
  logic [AW-1:0]  nxt_idx;
  logic           is_last;
  logic           hit;
  logic           finish;

  // A zero interval would never produce a fresh match, so it is stretched to 1.
  function automatic logic [BIN-1:0] ivl(input logic [BIN-1:0] t);
    return (t == '0) ? BIN'(1) : t;
  endfunction

  // Index of the last active segment, with seg_count clamped to 1..SEGS.
  function automatic logic [AW-1:0] last_of(input logic [AW:0] n);
    if (n == '0)
      return '0;
    else if (n > (AW+1)'(SEGS))
      return AW'(SEGS - 1);
    else
      return AW'(n - (AW+1)'(1));
  endfunction

  // Double-qualified match so a stale match flag from the counter is ignored.
  assign hit     = cnt_match && (cnt_value == cnt_match_value);
  assign is_last = (seg_idx == seg_last);
  assign nxt_idx = is_last ? '0 : seg_idx + AW'(1);

`ifdef COUNT_SEQ_REPEAT_EN
  assign finish  = is_last && (!loop || (rep_left == 8'd0));
`else
  assign finish  = is_last && !loop;
`endif

  // Interval table; host writes only land while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SEGS); i++) tbl[i] <= '0;
    end else if (cfg_we && (state == IDLE)) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Sequencer state machine with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt_enable      <= 1'b0;
      cnt_match_value <= '0;
      seg_idx         <= '0;
      seg_last        <= '0;
      seg_pulse       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef COUNT_SEQ_REPEAT_EN
      rep_left        <= 8'd0;
`endif
    end else begin
      seg_pulse <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          cnt_enable <= 1'b0;
          if (start && !stop) begin
            cnt_match_value <= cnt_value + ivl(tbl[0]);
            seg_idx         <= '0;
            seg_last        <= last_of(seg_count);
            busy            <= 1'b1;
            state           <= ARM;
`ifdef COUNT_SEQ_REPEAT_EN
            rep_left        <= rep_count;
`endif
          end
        end
        ARM: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt_enable <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            cnt_enable <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (hit) begin
            seg_pulse <= 1'b1;
            if (finish) begin
              cnt_enable <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= IDLE;
            end else begin
              seg_idx         <= nxt_idx;
              cnt_match_value <= cnt_match_value + ivl(tbl[nxt_idx]);
`ifdef COUNT_SEQ_REPEAT_EN
              if (is_last) rep_left <= rep_left - 8'd1;
`endif
            end
          end
        end
        default: begin
          cnt_enable <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
